// File: rtl/time_display_scan.sv
// time_display_scan: snapshots a packed time, converts it to BCD one bit per cycle,
// and multiplexes the selected page onto a 4-digit active-low 7-segment display.
module time_display_scan #(
  parameter int SAMPLE_DIV = 1000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] time_in,
  input  logic [1:0]  page_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        valid
);
  localparam int SW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0] idx_q, idx_d;
  logic [26:0] cap_q, cap_d;
  logic [4:0] bit_q, bit_d;
  logic [11:0] acc_q, acc_d, dab_v, shifted;
  logic [23:0] stage_q, stage_d;
  logic [35:0] dig_q, dig_d;
  logic [3:0] flag_q, flag_d;
  logic valid_q, valid_d;
  logic [3:0] an_q, an_d, dash, dpm;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, tick, scan_wrap, last;
  logic [15:0] nib;
  logic [3:0] cur;

  function automatic logic [11:0] dab(input logic [11:0] v);
    dab = v;
    for (int i = 0; i < 3; i++)
      if (v[4*i +: 4] > 4'd4) dab[4*i +: 4] = v[4*i +: 4] + 4'd3;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tick = samp_q == SW'(SAMPLE_DIV - 1);
    samp_d = tick ? '0 : samp_q + 1'b1;
    scan_wrap = scan_q == CW'(SCAN_DIV - 1);
    scan_d = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d = idx_q + {1'b0, scan_wrap};
    dab_v = dab(acc_q);
    shifted = 12'({dab_v, cap_q[5'd26 - bit_q]});
    last = bit_q == 5'd4 || bit_q == 5'd10 || bit_q == 5'd16;
    state_d = state_q;
    cap_d = cap_q;
    bit_d = bit_q;
    acc_d = acc_q;
    stage_d = stage_q;
    dig_d = dig_q;
    flag_d = flag_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = CONV;
        cap_d = time_in;
        bit_d = '0;
        acc_d = '0;
      end
      CONV: begin
        // each field converts in its own accumulator pass; the finished BCD is parked in stage
        acc_d = last ? '0 : shifted;
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd4) stage_d[23:16] = shifted[7:0];
        if (bit_q == 5'd10) stage_d[15:8] = shifted[7:0];
        if (bit_q == 5'd16) stage_d[7:0] = shifted[7:0];
        if (bit_q == 5'd26) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        dig_d = {stage_q, acc_q};
        valid_d = 1'b1;
        flag_d = {cap_q[26:22] > 5'd23, cap_q[21:16] > 6'd59, cap_q[15:10] > 6'd59, cap_q[9:0] > 10'd999};
      end
      default: state_d = IDLE;
    endcase
    nib = page_sel == 2'b00 ? dig_q[35:20] : page_sel == 2'b01 ? dig_q[27:12] : dig_q[15:0];
    dash = page_sel == 2'b00 ? {{2{flag_q[3]}}, {2{flag_q[2]}}} :
           page_sel == 2'b01 ? {{2{flag_q[2]}}, {2{flag_q[1]}}} : {flag_q[1], {3{flag_q[0]}}};
    dpm = page_sel[1] ? 4'b1000 : 4'b0100;
    cur = nib[{idx_q, 2'b00} +: 4];
    an_d = ~(4'b0001 << idx_q);
    seg_d = (!valid_q || page_sel == 2'b11) ? 7'b1111111 : dash[idx_q] ? 7'b0111111 : seg7(cur);
    dp_d = !(valid_q && page_sel != 2'b11 && dpm[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q <= '0;
      scan_q <= '0;
      idx_q <= '0;
      cap_q <= '0;
      bit_q <= '0;
      acc_q <= '0;
      stage_q <= '0;
      dig_q <= '0;
      flag_q <= '0;
      valid_q <= 1'b0;
      an_q <= 4'hf;
      seg_q <= 7'h7f;
      dp_q <= 1'b1;
    end else begin
      state_q <= state_d;
      samp_q <= samp_d;
      scan_q <= scan_d;
      idx_q <= idx_d;
      cap_q <= cap_d;
      bit_q <= bit_d;
      acc_q <= acc_d;
      stage_q <= stage_d;
      dig_q <= dig_d;
      flag_q <= flag_d;
      valid_q <= valid_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end

  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign busy = state_q != IDLE;
  assign valid = valid_q;
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: random and directed time snapshots checked by a scoreboard
// against an arithmetic model of what each display digit should show.
module tb_time_display_scan;
  localparam int SD = 64;
  localparam int CD = 4;
  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  typedef struct {int hr; int mi; int se; int ms;} tm_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [26:0] time_in = '0;
  logic [1:0] page_sel = 2'b01;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, busy, valid;
  int tests = 0;
  int fails = 0;
  tm_t exp_q[$];
  tm_t shown = '{0, 0, 0, 0};
  bit shown_v = 1'b0;
  bit done = 1'b0;

  time_display_scan #(.SAMPLE_DIV(SD), .SCAN_DIV(CD)) dut (
    .clk(clk), .reset(reset), .time_in(time_in), .page_sel(page_sel),
    .an(an), .seg(seg), .dp(dp), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] pk(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic tm_t unp(input logic [26:0] t);
    tm_t r;
    r.hr = int'(t[26:22]);
    r.mi = int'(t[21:16]);
    r.se = int'(t[15:10]);
    r.ms = int'(t[9:0]);
    return r;
  endfunction

  // expected {an, seg, dp} for one lit digit
  function automatic logic [11:0] model(input int idx, input logic [1:0] pg, input bit v, input tm_t t);
    int d[4];
    bit ds[4];
    int dpp;
    logic [3:0] a;
    logic [6:0] sg;
    a = 4'hf;
    a[idx] = 1'b0;
    dpp = 2;
    if (pg == 2'd0) begin
      d[3] = t.hr / 10; d[2] = t.hr % 10; d[1] = t.mi / 10; d[0] = t.mi % 10;
      ds[3] = t.hr > 23; ds[2] = t.hr > 23; ds[1] = t.mi > 59; ds[0] = t.mi > 59;
    end else if (pg == 2'd1) begin
      d[3] = t.mi / 10; d[2] = t.mi % 10; d[1] = t.se / 10; d[0] = t.se % 10;
      ds[3] = t.mi > 59; ds[2] = t.mi > 59; ds[1] = t.se > 59; ds[0] = t.se > 59;
    end else begin
      d[3] = t.se % 10; d[2] = t.ms / 100; d[1] = (t.ms / 10) % 10; d[0] = t.ms % 10;
      ds[3] = t.se > 59; ds[2] = t.ms > 999; ds[1] = t.ms > 999; ds[0] = t.ms > 999;
      dpp = 3;
    end
    if (!v || pg == 2'd3) sg = 7'h7f;
    else if (ds[idx]) sg = 7'b0111111;
    else sg = SEGS[d[idx]];
    return {a, sg, !(v && pg != 2'd3 && idx == dpp)};
  endfunction

  // monitor: outputs after edge N depend on state after edge N-1 and inputs at edge N
  initial begin
    int m = 0;
    int bcnt = 0;
    bit busy_p = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_disp", {an, seg, dp}, 12'hfff);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        m = 0;
        bcnt = 0;
        busy_p = 1'b0;
        shown_v = 1'b0;
        exp_q.delete();
      end else begin
        check("disp", {an, seg, dp}, model((m / CD) % 4, page_sel, shown_v, shown));
        m++;
        if (busy && !busy_p) check("tick_phase", m % SD, 0);
        if (busy) bcnt++;
        if (!busy && busy_p) begin
          check("busy_len", bcnt, 28);
          bcnt = 0;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty got=commit exp=none at %0t", $time);
          end else begin
            shown = exp_q.pop_front();
            shown_v = 1'b1;
          end
        end
        check("valid", valid, shown_v);
        busy_p = busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!done && $urandom_range(0, 5) == 0) page_sel = 2'($urandom_range(0, 3));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic txn(input logic [26:0] t, input int chg_at, input logic [26:0] t2, input bit rst10);
    int w = 0;
    time_in = t;
    while (!busy && w < 200) begin step(); w++; end
    if (w >= 200) begin
      fails++;
      $display("FAIL busy_rise_timeout got=0 exp=1 at %0t", $time);
      return;
    end
    exp_q.push_back(unp(t));
    if (rst10) begin
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      return;
    end
    if (chg_at > 0) begin
      repeat (chg_at - 1) step();
      time_in = t2;
    end
    w = 0;
    while (busy && w < 100) begin step(); w++; end
    if (w >= 100) begin
      fails++;
      $display("FAIL busy_fall_timeout got=1 exp=0 at %0t", $time);
    end
  endtask

  initial begin
    int h, mi, s, ms;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    txn(pk(12, 34, 56, 789), 0, '0, 0);
    txn(pk(5, 7, 60, 1000), 0, '0, 0);
    txn(pk(0, 0, 0, 0), 5, pk(23, 59, 59, 999), 0);
    txn(pk(23, 59, 59, 999), 0, '0, 0);
    txn(pk(9, 8, 7, 6), 0, '0, 1);
    txn(pk(1, 2, 3, 4), 0, '0, 0);
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(0, 3) == 0 ? $urandom_range(24, 31) : $urandom_range(0, 23);
      mi = $urandom_range(0, 3) == 0 ? $urandom_range(60, 63) : $urandom_range(0, 59);
      s = $urandom_range(0, 3) == 0 ? $urandom_range(60, 63) : $urandom_range(0, 59);
      ms = $urandom_range(0, 3) == 0 ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
      txn(pk(h, mi, s, ms), $urandom_range(0, 1) ? $urandom_range(1, 27) : 0, 27'($urandom), 0);
    end
    repeat (40) step();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000000, sets the clk cycles between time_in snapshots.
REQ-002 Parameter SCAN_DIV, default 100000, sets the clk cycles each display digit stays lit.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port time_in, input, 27 bits: packed time {hr[26:22], min[21:16], sec[15:10], ms[9:0]}, unsigned binary fields.
REQ-006 Port page_sel, input, 2 bits: display page; 00 = HH.MM, 01 = MM.SS, 10 = S.mmm, 11 = blank.
REQ-007 Port an, output, 4 bits: active-low digit anodes; an[3] is the leftmost digit.
REQ-008 Port seg, output, 7 bits: active-low cathodes with seg[0]=a through seg[6]=g.
REQ-009 Port dp, output, 1 bit: active-low decimal point.
REQ-010 Port busy, output, 1 bit: high while a BCD conversion is in progress.
REQ-011 Port valid, output, 1 bit: high once the digit registers hold at least one committed conversion.

Function
REQ-012 The sample counter SHALL count 0 to SAMPLE_DIV-1 and wrap; the tick occurs in the cycle where count = SAMPLE_DIV-1; the first tick occurs SAMPLE_DIV cycles after reset deasserts.
REQ-013 FSM states: IDLE, CONV, COMMIT; a tick in IDLE SHALL capture time_in at that edge (E0) and enter CONV.
- A tick arriving while the FSM is in CONV or COMMIT SHALL be dropped, not queued.
REQ-014 CONV SHALL run a serial double-dabble, 1 bit per cycle, MSB first, in field order hr(5), min(6), sec(6), ms(10).
- Shifts occur on edges E1 to E27.
- Add-3 correction applies per BCD nibble before each shift.
REQ-015 COMMIT on edge E28 SHALL load the digit registers, set valid=1 and return to IDLE.
- busy SHALL be 1 exactly after edges E0 through E27, i.e. 28 cycles.
REQ-016 Range check applies at commit. A field with hr>23, min>59, sec>59 or ms>999 SHALL be flagged out of range, and all of that field's displayed digits SHALL show a dash (seg=0111111).
REQ-017 Digit value encoding, seg[6:0], active-low:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Blank = 1111111.
REQ-018 There SHALL be no leading-zero blanking; every displayed field digit is shown.
REQ-019 Page content, listing digit 3 down to digit 0:
- 00 = hr tens, hr ones, min tens, min ones; dp lit on digit 2.
- 01 = min tens, min ones, sec tens, sec ones; dp lit on digit 2.
- 10 = sec ones, ms hundreds, ms tens, ms ones; dp lit on digit 3.
- 11 = all digits blank, dp off.
REQ-020 The scan counter SHALL count 0 to SCAN_DIV-1. On wrap, the 2-bit digit index SHALL increment modulo 4, in the order 0,1,2,3,0.
REQ-021 an, seg and dp SHALL be registered. They reflect the digit index, page_sel and digit registers with exactly one cycle of latency. an SHALL have exactly one bit low.
REQ-022 While valid=0, seg SHALL be blank and dp off, but anodes continue scanning.
REQ-023 time_in changes during CONV SHALL NOT affect the conversion in progress.

Reset
REQ-024 On reset, sample counter, scan counter and digit index SHALL be 0, and the FSM SHALL be in IDLE.
REQ-025 On reset, digit registers and range flags SHALL be 0, busy=0 and valid=0.
REQ-026 The cycle after reset asserts, outputs SHALL be an=1111, seg=1111111, dp=1.
REQ-027 Reset asserted during CONV SHALL abort the conversion with no commit; the digit registers keep no partial result.

Verification (SAMPLE_DIV=64, SCAN_DIV=4)
REQ-028 Reset held 3 cycles then released -> an=1111, seg=1111111, dp=1, busy=0, valid=0 after the first edge; valid still 0 at cycle 63.
REQ-029 time_in = 12:34:56.789, scanned through all pages:
- page_sel=01 -> digits 3..0 show 3,4,5,6 (0110000, 0011001, 0010010, 0000010), dp low only when digit 2 is lit.
- page_sel=00 -> digits show 1,2,3,4.
- page_sel=10 -> digits show 6,7,8,9, dp on digit 3.
- busy lasts exactly 28 cycles.
REQ-030 Out-of-range fields, time_in = hr 5, min 7, sec 60, ms 1000:
- page_sel=01 -> digits 0,7,-,-.
- page_sel=00 -> digits 0,5,0,7 (no leading blanking).
- page_sel=10 -> digits -,-,-,-.
REQ-031 time_in changed from 00:00:00.000 to 23:59:59.999 at E5 of a conversion -> the commit shows zeros; the next tick's commit shows 2,3,5,9 on page 00.
REQ-032 Reset asserted at E10 of a conversion -> busy=0 and valid=0 next cycle, seg blank; the next tick restarts conversion from E0.
REQ-033 page_sel switched 01 to 11 mid-scan -> seg=1111111, dp=1 from the next cycle; the anode rotation is unchanged.
